// File: rtl/ecc32_decode.sv
// SEC-DED decoder/corrector for the 32-data + 7-check Hamming code produced by ecc32_encode.
// Three register stages (capture, syndrome, classify/correct) plus saturating error-event counters.
module ecc32_decode #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      dec_in,
    input  logic [6:0]       parity_in,
    input  logic             valid_in,
    input  logic             cnt_clr,
    output logic [31:0]      dec_out,
    output logic             valid_out,
    output logic             err_single,
    output logic             err_double,
    output logic [6:0]       err_syndrome,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
);

    // Handshake: valid-only streaming. A word is accepted on any rising edge where
    // valid_in=1; there is no ready, so the source may present one word every cycle.
    // valid_out is a one-cycle qualifier for dec_out, err_* and err_syndrome.

    // Hamming position of data bit idx: the idx-th integer >= 3 that is not a power of two.
    function automatic logic [5:0] data_pos(input int idx);
        int         cnt;
        logic [5:0] res;
        cnt = 0;
        res = '0;
        for (int n = 3; n < 39; n++) begin
            if ((n & (n - 1)) != 0) begin
                if (cnt == idx) res = 6'(n);
                cnt++;
            end
        end
        return res;
    endfunction

    function automatic logic [5:0] calc_chk(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c ^ ({6{d[i]}} & data_pos(i));
        end
        return c;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0] s1_data;
    logic [6:0]  s1_par;
    logic        s1_valid;

    logic [31:0] s2_data;
    logic [5:0]  s2_syn;
    logic        s2_overall;
    logic        s2_valid;

    logic [31:0] flip_mask;
    logic [31:0] corrected;
    logic        class_single;
    logic        class_double;

    // Stage 1: capture raw word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_par   <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_data  <= dec_in;
            s1_par   <= parity_in;
            s1_valid <= valid_in;
        end
    end

    // Stage 2: syndrome and overall parity over all 39 received bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data    <= '0;
            s2_syn     <= '0;
            s2_overall <= 1'b0;
            s2_valid   <= 1'b0;
        end else begin
            s2_data    <= s1_data;
            s2_syn     <= calc_chk(s1_data) ^ s1_par[5:0];
            s2_overall <= (^s1_data) ^ (^s1_par);
            s2_valid   <= s1_valid;
        end
    end

    // Syndromes 1..38 with odd overall parity are exactly the correctable positions;
    // 0 points at the overall parity bit, powers of two at check bits, neither touches data.
    always_comb begin
        flip_mask = '0;
        for (int i = 0; i < 32; i++) begin
            if (s2_syn == data_pos(i)) flip_mask[i] = 1'b1;
        end
        class_single = s2_overall && (s2_syn <= 6'd38);
        class_double = (s2_overall && (s2_syn > 6'd38)) ||
                       (!s2_overall && (s2_syn != 6'd0));
        corrected    = class_single ? (s2_data ^ flip_mask) : s2_data;
    end

    // Stage 3: data/syndrome hold between valid words; flags are qualified pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_out      <= '0;
            err_syndrome <= '0;
            valid_out    <= 1'b0;
            err_single   <= 1'b0;
            err_double   <= 1'b0;
        end else begin
            valid_out  <= s2_valid;
            err_single <= s2_valid && class_single;
            err_double <= s2_valid && class_double;
            if (s2_valid) begin
                dec_out      <= corrected;
                err_syndrome <= {s2_overall, s2_syn};
            end
        end
    end

    // Counters: clear wins over a coincident event; saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            sec_cnt <= '0;
            ded_cnt <= '0;
        end else begin
            if (s2_valid && class_single && (sec_cnt != CNT_MAX)) sec_cnt <= sec_cnt + CNT_W'(1);
            if (s2_valid && class_double && (ded_cnt != CNT_MAX)) ded_cnt <= ded_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ecc32_decode.sv
// Directed bench for ecc32_decode: vector table, back-to-back flip sweep, counter and reset corners.
module tb_ecc32_decode;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      dec_in;
    logic [6:0]       parity_in;
    logic             valid_in;
    logic             cnt_clr;
    logic [31:0]      dec_out;
    logic             valid_out;
    logic             err_single;
    logic             err_double;
    logic [6:0]       err_syndrome;
    logic [CNT_W-1:0] sec_cnt;
    logic [CNT_W-1:0] ded_cnt;

    always #5 clk = ~clk;

    ecc32_decode #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_in       (dec_in),
        .parity_in    (parity_in),
        .valid_in     (valid_in),
        .cnt_clr      (cnt_clr),
        .dec_out      (dec_out),
        .valid_out    (valid_out),
        .err_single   (err_single),
        .err_double   (err_double),
        .err_syndrome (err_syndrome),
        .sec_cnt      (sec_cnt),
        .ded_cnt      (ded_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [5:0]  pos_tab [32];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] din;
        logic [6:0]  pin;
        logic [31:0] exp_data;
        logic [6:0]  exp_syn;
        logic        exp_s;
        logic        exp_d;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_pos();
        int idx;
        idx = 0;
        for (int n = 1; n <= 38; n++) begin
            if ($countones(n) != 1) begin
                pos_tab[idx] = 6'(n);
                idx++;
            end
        end
    endfunction

    function automatic logic [6:0] enc_par(input logic [31:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (d[i] && pos_tab[i][k]) c[k] = ~c[k];
            end
        end
        return {(^d) ^ (^c), c};
    endfunction

    // Drive one word, then wait (bounded) for valid_out; lat counts negedges after the drive edge.
    task automatic send_one(input logic [31:0] din, input logic [6:0] pin, output int lat);
        @(negedge clk);
        dec_in    = din;
        parity_in = pin;
        valid_in  = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    int          lat;
    int          exp_sec;
    int          exp_ded;
    int          got;
    int          first_c;
    int          last_c;
    int          hits;
    logic [6:0]  dp;
    logic [31:0] exp_d;

    initial begin
        rst       = 1'b1;
        dec_in    = '0;
        parity_in = '0;
        valid_in  = 1'b0;
        cnt_clr   = 1'b0;
        build_pos();
        dp = enc_par(32'hDEADBEEF);

        vecs[0]  = '{32'h0000_0000, 7'h00, 32'h0000_0000, 7'h00, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0001, 7'h00, 32'h0000_0000, 7'h43, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_0003, 7'h00, 32'h0000_0003, 7'h06, 1'b0, 1'b1};
        vecs[3]  = '{32'h0000_0000, 7'h7F, 32'h0000_0000, 7'h7F, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0000, 7'h01, 32'h0000_0000, 7'h41, 1'b1, 1'b0};
        vecs[5]  = '{32'h0000_0000, 7'h40, 32'h0000_0000, 7'h40, 1'b1, 1'b0};
        vecs[6]  = '{32'h8000_0000, 7'h00, 32'h0000_0000, 7'h66, 1'b1, 1'b0};
        vecs[7]  = '{32'h0200_0000, 7'h00, 32'h0000_0000, 7'h5F, 1'b1, 1'b0};
        vecs[8]  = '{32'h0000_0000, 7'h03, 32'h0000_0000, 7'h03, 1'b0, 1'b1};
        vecs[9]  = '{32'h0000_0000, 7'h67, 32'h0000_0000, 7'h67, 1'b0, 1'b1};
        vecs[10] = '{32'hDEADBEEF, dp, 32'hDEADBEEF, 7'h00, 1'b0, 1'b0};
        vecs[11] = '{32'hDEADBEEF ^ 32'h10, dp, 32'hDEADBEEF, 7'h49, 1'b1, 1'b0};
        vecs[12] = '{32'h0400_0000, 7'h00, 32'h0000_0000, 7'h61, 1'b1, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset valid_out", 64'(valid_out), 64'(0));
        check("reset dec_out", 64'(dec_out), 64'(0));
        check("reset err_syndrome", 64'(err_syndrome), 64'(0));
        check("reset flags", 64'({err_single, err_double}), 64'(0));
        check("reset counters", 64'({sec_cnt, ded_cnt}), 64'(0));

        exp_sec = 0;
        exp_ded = 0;
        for (int v = 0; v < 13; v++) begin
            send_one(vecs[v].din, vecs[v].pin, lat);
            if (vecs[v].exp_s) exp_sec++;
            if (vecs[v].exp_d) exp_ded++;
            check($sformatf("vec%0d latency", v), 64'(lat), 64'(3));
            check($sformatf("vec%0d dec_out", v), 64'(dec_out), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d err_syndrome", v), 64'(err_syndrome), 64'(vecs[v].exp_syn));
            check($sformatf("vec%0d err_single", v), 64'(err_single), 64'(vecs[v].exp_s));
            check($sformatf("vec%0d err_double", v), 64'(err_double), 64'(vecs[v].exp_d));
            check($sformatf("vec%0d sec_cnt", v), 64'(sec_cnt), 64'(exp_sec));
            check($sformatf("vec%0d ded_cnt", v), 64'(ded_cnt), 64'(exp_ded));
        end
        @(negedge clk);
        check("idle flags low", 64'({valid_out, err_single, err_double}), 64'(0));
        check("idle dec_out held", 64'(dec_out), 64'(32'h0000_0000));
        check("idle syndrome held", 64'(err_syndrome), 64'(7'h61));

        // Back-to-back sweep of every single-bit flip of encoded 0xDEADBEEF.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        exp_ded = 0;
        got = 0;
        first_c = -1;
        last_c = -1;
        fork
            begin
                for (int j = 0; j < 39; j++) begin
                    @(negedge clk);
                    dec_in    = 32'hDEADBEEF;
                    parity_in = dp;
                    if (j < 32) dec_in[j] = ~dec_in[j];
                    else parity_in[j - 32] = ~parity_in[j - 32];
                    valid_in = 1'b1;
                    exp_q.push_back(32'hDEADBEEF);
                end
                @(negedge clk);
                valid_in = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clk);
                    if (valid_out) begin
                        got++;
                        if (first_c < 0) first_c = c;
                        last_c = c;
                        if (exp_q.size() == 0) begin
                            check("sweep unexpected output", 64'(dec_out), 64'(32'hDEADBEEF));
                        end else begin
                            exp_d = exp_q.pop_front();
                            check("sweep dec_out", 64'(dec_out), 64'(exp_d));
                        end
                        check("sweep err_single", 64'({err_single, err_double}), 64'(2'b10));
                    end
                end
            end
        join
        check("sweep output count", 64'(got), 64'(39));
        check("sweep contiguous", 64'(last_c - first_c + 1), 64'(39));
        check("sweep queue drained", 64'(exp_q.size()), 64'(0));
        check("sweep sec_cnt", 64'(sec_cnt), 64'(39));
        check("sweep ded_cnt", 64'(ded_cnt), 64'(0));

        // Saturation: stream single errors up to one below the top, then past it.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr   = 1'b0;
        dec_in    = 32'h0000_0001;
        parity_in = 7'h00;
        for (int j = 0; j < 65534; j++) begin
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        check("sat sec_cnt below top", 64'(sec_cnt), 64'(16'hFFFE));
        for (int j = 0; j < 5; j++) begin
            valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        check("sat sec_cnt holds", 64'(sec_cnt), 64'(16'hFFFF));

        // cnt_clr in the same cycle the single-error flag is registered.
        @(negedge clk);
        dec_in    = 32'h0000_0001;
        parity_in = 7'h00;
        valid_in  = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        check("clr coincident valid", 64'({valid_out, err_single}), 64'(2'b11));
        check("clr coincident sec_cnt", 64'(sec_cnt), 64'(0));
        send_one(32'h0000_0001, 7'h00, lat);
        check("post clr sec_cnt", 64'(sec_cnt), 64'(1));
        send_one(32'h0000_0003, 7'h00, lat);
        check("post clr ded_cnt", 64'(ded_cnt), 64'(1));

        // Reset with three words in flight: none may emerge.
        hits = 0;
        @(negedge clk);
        dec_in   = 32'h0000_0001;
        valid_in = 1'b1;
        @(negedge clk);
        if (valid_out || err_single || err_double) hits++;
        dec_in = 32'h0000_0003;
        @(negedge clk);
        if (valid_out || err_single || err_double) hits++;
        dec_in = 32'h0000_0002;
        rst    = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        valid_in = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (valid_out || err_single || err_double) hits++;
            @(negedge clk);
        end
        check("flush no output", 64'(hits), 64'(0));
        check("flush sec_cnt", 64'(sec_cnt), 64'(0));
        check("flush ded_cnt", 64'(ded_cnt), 64'(0));

        send_one(32'h0000_0000, 7'h40, lat);
        check("recover latency", 64'(lat), 64'(3));
        check("recover flags", 64'({err_single, err_double}), 64'(2'b10));
        check("recover sec_cnt", 64'(sec_cnt), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
